// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle core: opcodes, branch condition
// codes and the bit positions of the {Z, V, N} flag vector.
package cpu_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // Flag vector is packed {Z, V, N}
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

endpackage

// File: rtl/flag_reg.sv
// Architectural condition flags plus the sticky halt latch. Once halted,
// flag writes are ignored until reset.
module flag_reg
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] alu_flags,
  input  logic [2:0] flag_we,
  input  logic       hlt_set,
  output logic [2:0] flags,
  output logic       halted
);

  // Per-bit flag update gated by halt; halt latch sets and holds until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 3'b000;
      halted <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flag_we[i] && !halted) flags[i] <= alu_flags[i];
      end
      if (hlt_set) halted <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC and halt control: decodes the control-flow class of the fetched
// instruction, evaluates branch conditions against the registered flags and
// drives fetch combinationally (zero-cycle latency).
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int OFFS_B = 9,
  parameter int OFFS_J = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  input  logic [15:0] reg_rs,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic [2:0]  flag_we,
  output logic [15:0] new_pc,
  output logic        br_ctrl,
  output logic        hlt,
  output logic [15:0] link,
  output logic [2:0]  flags,
  output logic        halted
);

  logic [3:0]               opcode;
  logic [2:0]               cc;
  logic signed [OFFS_B-1:0] offs_b;
  logic signed [OFFS_J-1:0] offs_j;
  logic signed [15:0]       offs_b_x;
  logic signed [15:0]       offs_j_x;
  logic [15:0]              tgt_b;
  logic [15:0]              tgt_j;
  logic [2:0]               alu_flags;

  function automatic logic cond_true(input logic [2:0] code, input logic [2:0] f);
    logic z, v, n, r;
    z = f[FLG_Z];
    v = f[FLG_V];
    n = f[FLG_N];
    case (code)
      CC_NEQ:  r = !z;
      CC_EQ:   r = z;
      CC_GT:   r = !z && !n;
      CC_LT:   r = n;
      CC_GTE:  r = z || !n;
      CC_LTE:  r = n || z;
      CC_OVFL: r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign opcode    = instr[15:12];
  assign cc        = instr[11:9];
  assign offs_b    = instr[OFFS_B-1:0];
  assign offs_j    = instr[OFFS_J-1:0];
  assign offs_b_x  = 16'(offs_b);
  assign offs_j_x  = 16'(offs_j);
  assign alu_flags = {alu_z, alu_v, alu_n};

  // PC arithmetic wraps at 16 bits; link is always pc+1
  assign link  = pc + 16'd1;
  assign tgt_b = link + offs_b_x;
  assign tgt_j = link + offs_j_x;

  // Redirect decode; branches use pre-edge flags, and halt suppresses redirect
  always_comb begin
    new_pc  = tgt_b;
    br_ctrl = 1'b0;
    hlt     = halted;
    case (opcode)
      OP_B: begin
        new_pc  = tgt_b;
        br_ctrl = cond_true(cc, flags);
      end
      OP_JAL: begin
        new_pc  = tgt_j;
        br_ctrl = 1'b1;
      end
      OP_JR: begin
        new_pc  = reg_rs;
        br_ctrl = 1'b1;
      end
      OP_HLT: hlt = 1'b1;
      default: ;
    endcase
    if (halted) br_ctrl = 1'b0;
  end

  flag_reg u_flag_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_flags (alu_flags),
    .flag_we   (flag_we),
    .hlt_set   (hlt),
    .flags     (flags),
    .halted    (halted)
  );

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Next-PC and halt control for the single-cycle core, sitting directly upstream of instruction fetch. It decodes the control-flow class of the currently fetched instruction, holds the architectural condition flags (Z, V, N), evaluates branch conditions, and drives the fetch stage's `new_pc`, `br_ctrl` and `hlt` inputs. It also produces the JAL link value and a sticky `halted` status for the bench.

## Interface
- `OFFS_B`, default 9: width of the signed branch offset, taken from `instr[8:0]`.
- `OFFS_J`, default 12: width of the signed JAL offset, taken from `instr[11:0]`.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 16: the instruction currently fetched.
- `pc` in 16: address of `instr`.
- `reg_rs` in 16: register-file read data for the `rs` field (`instr[7:4]`), used by JR.
- `alu_z`, `alu_v`, `alu_n` in 1 each: flag results of the current instruction.
- `flag_we` in 3: per-flag write enables {Z, V, N} from the decoder.
- `new_pc` out 16: redirect target.
- `br_ctrl` out 1: when 1, fetch loads `new_pc`; when 0, fetch loads `pc+1`.
- `hlt` out 1: freezes the PC.
- `link` out 16: `pc+1`, the write-back value for JAL.
- `flags` out 3: registered {Z, V, N}.
- `halted` out 1: sticky halt status.

## Operation
- Opcode is `instr[15:12]`:
  - B = 4'hC
  - JAL = 4'hD
  - JR = 4'hE
  - HLT = 4'hF
  - All other opcodes are non-control-flow and drive `br_ctrl`=0.
- B:
  - The condition code is `instr[11:9]`.
  - `new_pc` = `pc` + 1 + sext(`instr[8:0]`).
  - `br_ctrl` = 1 only when the condition is true.
- Condition codes:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- JAL: `new_pc` = `pc` + 1 + sext(`instr[11:0]`), `br_ctrl` = 1. `link` is valid for every instruction.
- JR: `new_pc` = `reg_rs`, `br_ctrl` = 1.
- HLT: `hlt` = 1 combinationally. `halted` sets at the next edge and stays set until reset.
- While `halted`=1:
  - `hlt` is held at 1 regardless of `instr`.
  - `br_ctrl` = 0.
  - Flag writes are blocked.
- All PC arithmetic is 16-bit unsigned with wrap-around (0xFFFF + 1 = 0x0000); there is no overflow detection on PC.
- A non-taken B drives `new_pc` to the computed target anyway, with `br_ctrl` = 0.

## Timing
- Reset values: `flags` = 3'b000 and `halted` = 0. Combinational outputs follow from these and the inputs: `hlt` = 0 unless `instr` is HLT.
- `new_pc`, `br_ctrl`, `hlt` and `link` are purely combinational from `instr`, `pc`, `reg_rs`, `flags` and `halted`. There is zero-cycle latency into fetch, which consumes them at the same edge.
- Flags:
  - Flag bit i updates at the rising edge when `flag_we[i]`=1 and `halted`=0.
  - A branch always evaluates the pre-edge flags, so a flag write and a branch in the same cycle use the old flags.
- Reset asserted mid-operation clears `flags` and `halted` immediately (asynchronously). Outputs re-evaluate the same cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (`OP_B`, `OP_JAL`, `OP_JR`, `OP_HLT`);
  - condition-code constants (`CC_NEQ` … `CC_UNCOND`);
  - flag index constants (`FLG_Z`, `FLG_V`, `FLG_N`).
- One sub-module, `flag_reg`: the three flags plus the halt latch, with async reset, per-bit enable and the halt gating.
- Condition evaluation and target adders live in `pc_ctrl`.

## Test plan
- Reset, then `instr`=0x0000 with `pc`=0x0010 → `br_ctrl`=0, `hlt`=0, `link`=0x0011, `flags`=000.
- Write Z=1 via `flag_we`=100, then `instr`=0xC203 (EQ, +3) with `pc`=0x0020 → `br_ctrl`=1, `new_pc`=0x0024. Then `instr`=0xC003 (NEQ) → `br_ctrl`=0.
- `instr`=0xC1FF (NEQ, −1) with Z=0 and `pc`=0x0000 → `new_pc`=0x0000. `instr`=0xDFFE (JAL −2) with `pc`=0xFFFF → `new_pc`=0xFFFE and `link`=0x0000 (wrap).
- JR with `reg_rs`=0xABCD → `new_pc`=0xABCD, `br_ctrl`=1. In the same cycle set `flag_we`=111 and `alu_*`=1 → `flags`=111 after the edge, and the branch result is unaffected.
- `instr`=0xF000 → `hlt`=1 combinationally and `halted`=1 after the edge. Then `instr`=0xCE00 (UNCOND) with `flag_we`=111 → `hlt`=1, `br_ctrl`=0, flags unchanged.
- Assert `rst_n`=0 between edges while `halted`=1 → `halted`=0 and `flags`=000 without waiting for a clock edge.
